data_ram_ws: RTL

Parametrised, byte-banked data RAM for the MEM stage with a configurable number of wait states. While an access is in flight it raises `stallreq` toward the pipeline controller, so load and store latency can be swept without changing the core. It replaces the fixed zero-latency data RAM in `openmips_min_sopc`. Storage is organised as `BANKS` byte-wide banks, `bank0` holding the least-significant byte.

---
 rtl/data_ram_ws.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/data_ram_ws.sv
// Byte-banked MEM-stage data RAM with WAIT_CYC wait states; raises stallreq while an access is in flight.
// Optional misalignment checking is compiled in with `define DRAM_ALIGN_CHK_EN.
module data_ram_ws #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned BANKS    = 4,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [BANKS-1:0]     sel,
  input  logic [8*BANKS-1:0]   data_i,
  output logic [8*BANKS-1:0]   data_o,
  output logic                 stallreq,
  output logic                 ack,
  output logic                 err
);

  localparam int unsigned DATA_W = 8 * BANKS;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   data_o_q, data_o_d;
  logic [BANKS-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic                mis_q, mis_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   ram_word;
  logic [BANKS-1:0]    wr_lane;
  logic                misalign;
  logic                unused_addr;

  assign idx         = addr[ADDR_W+1:2];
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  function automatic logic [DATA_W-1:0] lane_mask(input logic [BANKS-1:0] s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BANKS); i++) begin
      m[8*i +: 8] = {8{s[i]}};
    end
    return m;
  endfunction

  // One byte-wide array per lane; written only at the accept edge, never reset.
  for (genvar b = 0; b < int'(BANKS); b++) begin : g_bank
    logic [7:0] bank_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_lane[b]) begin
        bank_mem[idx] <= data_i[8*b +: 8];
      end
    end

    assign ram_word[8*b +: 8] = bank_mem[idx];
  end

`ifdef DRAM_ALIGN_CHK_EN
  always_comb begin
    misalign = 1'b0;
    if ((sel == '1) && (addr[1:0] != 2'b00)) begin
      misalign = 1'b1;
    end
    if ((BANKS == 4) && ((sel == BANKS'(4'b0011)) || (sel == BANKS'(4'b1100))) && addr[0]) begin
      misalign = 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // Next-state, capture and output decode; ack/data_o/err are staged one edge early so they leave flops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    sel_d    = sel_q;
    we_d     = we_q;
    mis_d    = mis_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    data_o_d = '0;
    wr_lane  = '0;
    stallreq = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ce && rst) begin
          stallreq = 1'b1;
          state_d  = S_BUSY;
          cnt_d    = CNT_W'(WAIT_CYC);
          sel_d    = sel;
          we_d     = we;
          mis_d    = misalign;
          if (we) begin
            if (!misalign) begin
              wr_lane = sel;
            end
          end else begin
            rdata_d = ram_word;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          stallreq = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Entering BUSY with an exhausted counter means the next cycle is the ack cycle.
    if ((state_d == S_BUSY) && (cnt_d == '0)) begin
      ack_d = 1'b1;
      err_d = mis_d;
      if (!we_d && !mis_d) begin
        data_o_d = rdata_d & lane_mask(sel_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      data_o_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      mis_q    <= mis_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      data_o_q <= data_o_d;
    end
  end

  assign data_o = data_o_q;
  assign ack    = ack_q;
  assign err    = err_q;

endmodule
